// File: rtl/nes_bridge_pkg.sv
// Shared types and constants for the NES-controller I2C bridge.
// The optional init sequence is selected in nes_bridge by NES_BRIDGE_INIT_EN.
package nes_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_STOP,
    ST_GAP
  } state_e;

  typedef enum logic [2:0] {
    CMD_START,
    CMD_STOP,
    CMD_WRITE,
    CMD_READ,
    CMD_GAP
  } cmd_e;

  // Bus segments between START and STOP, run in ascending order.
  typedef enum logic [1:0] {
    SEG_INIT0,
    SEG_INIT1,
    SEG_PTR,
    SEG_RD
  } seg_e;

  localparam logic [7:0] ADDR_WR   = 8'hA4;
  localparam logic [7:0] ADDR_RD   = 8'hA5;
  localparam logic [7:0] REG_PTR   = 8'h00;
  localparam logic [7:0] INIT0_REG = 8'hF0;
  localparam logic [7:0] INIT0_VAL = 8'h55;
  localparam logic [7:0] INIT1_REG = 8'hFB;
  localparam logic [7:0] INIT1_VAL = 8'h00;

  // Byte idx of a segment's write phase; byte 0 is always the address byte.
  function automatic logic [7:0] seg_byte(input seg_e seg, input logic [1:0] idx,
                                          input logic [7:0] wr_addr);
    logic [7:0] b;
    b = wr_addr;
    case (seg)
      SEG_INIT0: begin
        if (idx == 2'd1) b = INIT0_REG;
        else if (idx == 2'd2) b = INIT0_VAL;
      end
      SEG_INIT1: begin
        if (idx == 2'd1) b = INIT1_REG;
        else if (idx == 2'd2) b = INIT1_VAL;
      end
      SEG_PTR: begin
        if (idx == 2'd1) b = REG_PTR;
      end
      default: b = wr_addr | (ADDR_RD ^ ADDR_WR);
    endcase
    return b;
  endfunction

  // Index of the last written byte in a segment.
  function automatic logic [1:0] seg_last(input seg_e seg);
    logic [1:0] n;
    case (seg)
      SEG_INIT0, SEG_INIT1: n = 2'd2;
      SEG_PTR:              n = 2'd1;
      default:              n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/nes_bridge_i2c_bit_engine.sv
// Quarter-period I2C bit engine: runs one START/STOP/WRITE/READ/GAP bit
// and owns the open-drain pull-down controls for SCL and SDA.
module i2c_bit_engine
  import nes_bridge_pkg::*;
#(
  parameter int unsigned QUARTER = 12
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cmd_valid_i,
  input  cmd_e cmd_i,
  input  logic wbit_i,
  input  logic sda_i,
  output logic bit_done_o,
  output logic rbit_o,
  output logic scl_low_o,
  output logic sda_low_o
);

  localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

  logic          active_q;
  cmd_e          cmd_q;
  logic          wbit_q;
  logic [1:0]    phase_q;
  logic [QW-1:0] qcnt_q;
  logic          done_q;
  logic          rbit_q;
  logic          scl_low_q, scl_low_d;
  logic          sda_low_q, sda_low_d;

  // Line levels per quarter; lines hold their level between bits.
  always_comb begin
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;
    if (active_q) begin
      case (cmd_q)
        CMD_START: begin
          scl_low_d = (phase_q == 2'd3);
          sda_low_d = phase_q[1];
        end
        CMD_STOP: begin
          scl_low_d = (phase_q == 2'd0);
          sda_low_d = (phase_q != 2'd3);
        end
        CMD_WRITE: begin
          scl_low_d = (phase_q == 2'd0) || (phase_q == 2'd3);
          sda_low_d = !wbit_q;
        end
        CMD_READ: begin
          scl_low_d = (phase_q == 2'd0) || (phase_q == 2'd3);
          sda_low_d = 1'b0;
        end
        default: begin
          scl_low_d = 1'b0;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      cmd_q     <= CMD_START;
      wbit_q    <= 1'b1;
      phase_q   <= 2'd0;
      qcnt_q    <= '0;
      done_q    <= 1'b0;
      rbit_q    <= 1'b1;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
      if (!active_q) begin
        if (cmd_valid_i) begin
          active_q <= 1'b1;
          cmd_q    <= cmd_i;
          wbit_q   <= wbit_i;
          phase_q  <= 2'd0;
          qcnt_q   <= '0;
        end
      end else if (qcnt_q == QLAST) begin
        qcnt_q  <= '0;
        phase_q <= phase_q + 2'd1;
        if (phase_q == 2'd2) rbit_q <= sda_i;
        if (phase_q == 2'd3) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end else begin
        qcnt_q <= qcnt_q + QW'(1);
      end
    end
  end

  assign bit_done_o = done_q;
  assign rbit_o     = rbit_q;
  assign scl_low_o  = scl_low_q;
  assign sda_low_o  = sda_low_q;

endmodule

// File: rtl/nes_bridge.sv
// I2C master polling a Nintendo-style controller and caching 4 report bytes.
// Define NES_BRIDGE_INIT_EN to send the unencrypted-mode init writes once after reset.
module nes_bridge
  import nes_bridge_pkg::*;
#(
  parameter int unsigned QUARTER   = 12,
  parameter logic [6:0]  DEV_ADDR  = ADDR_WR[7:1],
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] rdata_addr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       error,
  output wire        scl,
  inout  wire        sda
);

  localparam logic [1:0] LAST_RX = 2'(NUM_BYTES - 1);
  localparam logic [7:0] WR_ADDR = {DEV_ADDR, 1'b0};

  state_e     state_q;
  seg_e       seg_q;
  seg_e       first_seg;
  logic [1:0] byte_q;
  logic [2:0] bit_q;
  logic [6:0] sh_q;
  logic       cmd_valid_q;
  cmd_e       cmd_q;
  logic       wbit_q;
  logic       busy_q;
  logic       error_q;
  logic [7:0] rx_buf_q [4];

  logic       bit_done;
  logic       rbit;
  logic       scl_low;
  logic       sda_low;
  logic [7:0] tx_byte_c;

  // In TX_ACK the byte needed is the one about to be sent.
  assign tx_byte_c = seg_byte(seg_q, (state_q == ST_TX_ACK) ? byte_q + 2'd1 : byte_q, WR_ADDR);

`ifdef NES_BRIDGE_INIT_EN
  logic inited_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inited_q <= 1'b0;
    else if (state_q == ST_STOP && bit_done && seg_q == SEG_INIT1 && !error_q) inited_q <= 1'b1;
  end

  assign first_seg = inited_q ? SEG_PTR : SEG_INIT0;
`else
  assign first_seg = SEG_PTR;
`endif

  i2c_bit_engine #(
    .QUARTER(QUARTER)
  ) u_bit (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid_q),
    .cmd_i      (cmd_q),
    .wbit_i     (wbit_q),
    .sda_i      (sda),
    .bit_done_o (bit_done),
    .rbit_o     (rbit),
    .scl_low_o  (scl_low),
    .sda_low_o  (sda_low)
  );

  // Byte/phase sequencer; every transition issues the next bit command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seg_q       <= SEG_PTR;
      byte_q      <= 2'd0;
      bit_q       <= 3'd0;
      sh_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_START;
      wbit_q      <= 1'b1;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      for (int i = 0; i < 4; i++) rx_buf_q[i] <= 8'h00;
    end else begin
      cmd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            seg_q       <= first_seg;
            byte_q      <= 2'd0;
            state_q     <= ST_START;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q     <= ST_TX_BYTE;
            bit_q       <= 3'd7;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_WRITE;
            wbit_q      <= tx_byte_c[7];
          end
        end
        ST_TX_BYTE: begin
          if (bit_done) begin
            cmd_valid_q <= 1'b1;
            if (bit_q == 3'd0) begin
              state_q <= ST_TX_ACK;
              cmd_q   <= CMD_READ;
            end else begin
              bit_q  <= bit_q - 3'd1;
              cmd_q  <= CMD_WRITE;
              wbit_q <= tx_byte_c[bit_q - 3'd1];
            end
          end
        end
        ST_TX_ACK: begin
          if (bit_done) begin
            cmd_valid_q <= 1'b1;
            if (rbit) begin
              error_q <= 1'b1;
              state_q <= ST_STOP;
              cmd_q   <= CMD_STOP;
            end else if (byte_q != seg_last(seg_q)) begin
              byte_q  <= byte_q + 2'd1;
              bit_q   <= 3'd7;
              state_q <= ST_TX_BYTE;
              cmd_q   <= CMD_WRITE;
              wbit_q  <= tx_byte_c[7];
            end else if (seg_q == SEG_RD) begin
              byte_q  <= 2'd0;
              bit_q   <= 3'd7;
              state_q <= ST_RX_BYTE;
              cmd_q   <= CMD_READ;
            end else begin
              state_q <= ST_STOP;
              cmd_q   <= CMD_STOP;
            end
          end
        end
        ST_RX_BYTE: begin
          if (bit_done) begin
            sh_q        <= {sh_q[5:0], rbit};
            cmd_valid_q <= 1'b1;
            if (bit_q == 3'd0) begin
              rx_buf_q[byte_q] <= {sh_q, rbit};
              state_q <= ST_RX_ACK;
              cmd_q   <= CMD_WRITE;
              wbit_q  <= (byte_q == LAST_RX);
            end else begin
              bit_q <= bit_q - 3'd1;
              cmd_q <= CMD_READ;
            end
          end
        end
        ST_RX_ACK: begin
          if (bit_done) begin
            cmd_valid_q <= 1'b1;
            if (byte_q == LAST_RX) begin
              state_q <= ST_STOP;
              cmd_q   <= CMD_STOP;
            end else begin
              byte_q  <= byte_q + 2'd1;
              bit_q   <= 3'd7;
              state_q <= ST_RX_BYTE;
              cmd_q   <= CMD_READ;
            end
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (error_q || seg_q == SEG_RD) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= ST_GAP;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CMD_GAP;
            end
          end
        end
        ST_GAP: begin
          if (bit_done) begin
            seg_q       <= seg_e'(seg_q + 2'd1);
            byte_q      <= 2'd0;
            state_q     <= ST_START;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_START;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign scl   = scl_low ? 1'b0 : 1'bz;
  assign sda   = sda_low ? 1'b0 : 1'bz;
  assign rdata = rx_buf_q[rdata_addr];
  assign busy  = busy_q;
  assign error = error_q;

endmodule

// File: tb/tb_nes_bridge.sv
// Bench for nes_bridge: clock-sampled I2C slave model at 0x52 plus directed polls.
module tb_nes_bridge;

  localparam int unsigned QUARTER = 12;
  localparam int LIMIT = 20000;
`ifdef NES_BRIDGE_INIT_EN
  localparam bit INIT_BUILD = 1'b1;
  localparam int POLL_MAX = 10000;
`else
  localparam bit INIT_BUILD = 1'b0;
  localparam int POLL_MAX = 5000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rdata_addr = 2'd0;
  logic [7:0] rdata;
  logic       busy, error;
  wire        scl_w, sda_w;
  logic       slv_low = 1'b0;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = slv_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  nes_bridge #(.QUARTER(QUARTER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rdata_addr(rdata_addr),
    .rdata     (rdata),
    .busy      (busy),
    .error     (error),
    .scl       (scl_w),
    .sda       (sda_w)
  );

  // Slave model state
  logic       present = 1'b0;
  logic [7:0] slv_data [4];
  logic [7:0] wlog [$];
  logic       mack [$];
  int         n_start = 0, n_stop = 0;
  logic       s_active = 1'b0, s_dphase = 1'b0, s_addr_ok = 1'b0, s_rd = 1'b0, s_mack = 1'b1;
  logic [7:0] s_sh = 8'h00;
  int         s_bit = 0, s_byte = 0, s_didx = 0;
  logic       pscl = 1'b1, psda = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_low = 1'b0; s_active = 1'b0; s_dphase = 1'b0; s_bit = 0;
        pscl = 1'b1; psda = 1'b1;
      end else begin
        if (pscl && scl_w && psda && !sda_w) begin
          s_active = 1'b1; s_dphase = 1'b0; s_addr_ok = 1'b0;
          s_bit = 0; s_byte = 0; slv_low = 1'b0; n_start++;
        end else if (pscl && scl_w && !psda && sda_w) begin
          s_active = 1'b0; s_dphase = 1'b0; slv_low = 1'b0; n_stop++;
        end else if (s_active && !pscl && scl_w) begin
          if (s_bit < 8 && !s_dphase) s_sh = {s_sh[6:0], sda_w};
          if (s_bit == 8 && s_dphase) begin
            s_mack = sda_w;
            mack.push_back(sda_w);
          end
          s_bit++;
        end else if (s_active && pscl && !scl_w) begin
          if (s_bit == 8) begin
            if (s_dphase) slv_low = 1'b0;
            else begin
              wlog.push_back(s_sh);
              if (s_byte == 0) begin
                s_addr_ok = present && (s_sh[7:1] == 7'h52);
                s_rd = s_sh[0];
              end
              slv_low = s_addr_ok;
              s_byte++;
            end
          end else if (s_bit == 9) begin
            s_bit = 0;
            slv_low = 1'b0;
            if (!s_dphase) begin
              if (s_addr_ok && s_rd) begin
                s_dphase = 1'b1; s_didx = 0;
                slv_low = !slv_data[0][7];
              end
            end else if (!s_mack && s_didx < 3) begin
              s_didx++;
              slv_low = !slv_data[s_didx][7];
            end else begin
              s_dphase = 1'b0;
            end
          end else if (s_dphase && s_bit > 0) begin
            slv_low = !slv_data[s_didx][7 - s_bit];
          end
        end
        pscl = scl_w;
        psda = sda_w;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         scen;
    logic [1:0] addr;
    logic [7:0] exp;
  } rvec_t;
  rvec_t rtab [$];

  task automatic add4(input int s, input logic [7:0] b0, b1, b2, b3);
    rtab.push_back('{s, 2'd0, b0});
    rtab.push_back('{s, 2'd1, b1});
    rtab.push_back('{s, 2'd2, b2});
    rtab.push_back('{s, 2'd3, b3});
  endtask

  task automatic check_rdata(input int s);
    for (int i = 0; i < rtab.size(); i++) begin
      if (rtab[i].scen == s) begin
        rdata_addr = rtab[i].addr;
        #1;
        check($sformatf("rdata_s%0d_a%0d", s, rtab[i].addr), 32'(rdata), 32'(rtab[i].exp));
      end
    end
  endtask

  task automatic set_data(input logic [7:0] b0, b1, b2, b3);
    slv_data[0] = b0; slv_data[1] = b1; slv_data[2] = b2; slv_data[3] = b3;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Runs one poll; dbl fires a second start while busy.
  task automatic run_poll(input bit ok, input bit dbl, output int cyc);
    wlog.delete(); mack.delete(); n_start = 0; n_stop = 0; present = ok;
    pulse_start();
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      if (dbl && cyc == 300) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc++;
      end
    end
    check("busy_falls", 32'(busy), 32'd0);
    repeat (QUARTER * 8) @(posedge clk);
    #1;
  endtask

  bit tb_inited = 1'b0;

  task automatic verify_poll(input string tag, input bit ok, input int cyc);
    logic [7:0] exp_w [$];
    bit with_init;
    int nseg;
    with_init = INIT_BUILD && !tb_inited;
    if (with_init) begin
      exp_w.push_back(8'hA4);
      if (ok) begin
        exp_w.push_back(8'hF0); exp_w.push_back(8'h55);
        exp_w.push_back(8'hA4); exp_w.push_back(8'hFB); exp_w.push_back(8'h00);
        exp_w.push_back(8'hA4); exp_w.push_back(8'h00); exp_w.push_back(8'hA5);
      end
    end else begin
      exp_w.push_back(8'hA4);
      if (ok) begin
        exp_w.push_back(8'h00); exp_w.push_back(8'hA5);
      end
    end
    nseg = !ok ? 1 : (with_init ? 4 : 2);
    check({tag, "_starts"}, 32'(n_start), 32'(nseg));
    check({tag, "_stops"}, 32'(n_stop), 32'(nseg));
    check({tag, "_wlen"}, 32'(wlog.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      if (i < wlog.size()) check($sformatf("%s_wbyte%0d", tag, i), 32'(wlog[i]), 32'(exp_w[i]));
    check({tag, "_error"}, 32'(error), ok ? 32'd0 : 32'd1);
    if (ok) begin
      check({tag, "_macklen"}, 32'(mack.size()), 32'd4);
      for (int i = 0; i < 4; i++)
        if (i < mack.size()) check($sformatf("%s_mack%0d", tag, i), 32'(mack[i]), (i == 3) ? 32'd1 : 32'd0);
      check({tag, "_time"}, 32'(cyc < POLL_MAX), 32'd1);
      tb_inited = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit hit;
    add4(0, 8'h00, 8'h00, 8'h00, 8'h00);
    add4(1, 8'h00, 8'h00, 8'h00, 8'h00);
    add4(2, 8'h41, 8'h42, 8'h43, 8'h44);
    add4(3, 8'h00, 8'h00, 8'h00, 8'h00);
    add4(4, 8'h5A, 8'hA5, 8'h00, 8'hFF);
    add4(5, 8'hC3, 8'h3C, 8'h81, 8'h7E);

    // Reset state
    set_data(8'h41, 8'h42, 8'h43, 8'h44);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl_w), 32'd1);
    check("rst_sda", 32'(sda_w), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check_rdata(0);

    // No slave: address NACK
    run_poll(1'b0, 1'b0, cyc);
    verify_poll("noslv", 1'b0, cyc);
    check_rdata(1);

    // Normal poll with an ignored second start
    run_poll(1'b1, 1'b1, cyc);
    verify_poll("poll1", 1'b1, cyc);
    check_rdata(2);

    // Reset in the middle of receiving byte 1
    set_data(8'h5A, 8'hA5, 8'h00, 8'hFF);
    wlog.delete(); mack.delete(); present = 1'b1;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(posedge clk); #1;
      if (s_dphase && s_didx == 1 && s_bit == 3 && scl_w == 1'b0) hit = 1'b1;
    end
    check("rx_reset_reached", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("rx_reset_scl", 32'(scl_w), 32'd1);
    check("rx_reset_busy", 32'(busy), 32'd0);
    check_rdata(3);
    repeat (3) @(posedge clk);
    #1;
    check("rx_reset_sda", 32'(sda_w), 32'd1);
    rst = 1'b0;
    tb_inited = 1'b0;
    repeat (3) @(posedge clk);

    // Poll after reset
    run_poll(1'b1, 1'b0, cyc);
    verify_poll("poll2", 1'b1, cyc);
    check_rdata(4);

    // Repeat poll: no init writes any more
    set_data(8'hC3, 8'h3C, 8'h81, 8'h7E);
    run_poll(1'b1, 1'b0, cyc);
    verify_poll("poll3", 1'b1, cyc);
    check_rdata(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
